// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32 opcode/funct constants and the issue-register bubble value.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_XOR = 3'b011,
    ALU_MUL = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRA = 3'b110
  } alu_op_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
    logic       valid;
    alu_op_e    alu_op;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
  } issue_ctrl_t;

  localparam issue_ctrl_t CTRL_BUBBLE =
    '{1'b0, ALU_ADD, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV32 subset decoder: instruction word to ALU op, immediate,
// control enables, register fields and an illegal flag.
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [31:0]       i_instr,
  output alu_op_e           o_alu_op_c,
  output logic [DATA_W-1:0] o_imm_c,
  output logic              o_use_imm_c,
  output logic              o_rs2_used_c,
  output logic              o_reg_write_c,
  output logic              o_mem_read_c,
  output logic              o_mem_write_c,
  output logic              o_branch_c,
  output logic              o_illegal_c,
  output logic [4:0]        o_rs1_c,
  output logic [4:0]        o_rs2_c,
  output logic [4:0]        o_rd_c
);

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic [DATA_W-1:0] w_imm_i;
  logic [DATA_W-1:0] w_imm_s;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign o_rd_c   = i_instr[11:7];
  assign o_rs1_c  = i_instr[19:15];
  assign o_rs2_c  = i_instr[24:20];
  assign w_imm_i  = {{(DATA_W-12){i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{(DATA_W-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};

  // Anything not matched below stays illegal.
  always_comb begin
    o_alu_op_c    = ALU_ADD;
    o_imm_c       = '0;
    o_use_imm_c   = 1'b0;
    o_rs2_used_c  = 1'b0;
    o_reg_write_c = 1'b0;
    o_mem_read_c  = 1'b0;
    o_mem_write_c = 1'b0;
    o_branch_c    = 1'b0;
    o_illegal_c   = 1'b1;
    case (w_opcode)
      OPC_R: begin
        o_rs2_used_c  = 1'b1;
        o_reg_write_c = 1'b1;
        o_illegal_c   = 1'b0;
        case ({w_funct7, w_funct3})
          {F7_BASE, F3_ADD}: o_alu_op_c = ALU_ADD;
          {F7_ALT,  F3_ADD}: o_alu_op_c = ALU_SUB;
          {F7_BASE, F3_AND}: o_alu_op_c = ALU_AND;
          {F7_BASE, F3_XOR}: o_alu_op_c = ALU_XOR;
          {F7_MUL,  F3_ADD}: o_alu_op_c = ALU_MUL;
          {F7_BASE, F3_SLL}: o_alu_op_c = ALU_SLL;
          default:           o_illegal_c = 1'b1;
        endcase
      end
      OPC_I: begin
        if (w_funct3 == F3_ADD) begin
          o_imm_c       = w_imm_i;
          o_use_imm_c   = 1'b1;
          o_reg_write_c = 1'b1;
          o_illegal_c   = 1'b0;
        end else if (w_funct3 == F3_SR && w_funct7 == F7_ALT) begin
          o_alu_op_c    = ALU_SRA;
          o_imm_c       = DATA_W'(i_instr[24:20]);
          o_use_imm_c   = 1'b1;
          o_reg_write_c = 1'b1;
          o_illegal_c   = 1'b0;
        end
      end
      OPC_LOAD: begin
        if (w_funct3 == F3_WORD) begin
          o_imm_c       = w_imm_i;
          o_use_imm_c   = 1'b1;
          o_reg_write_c = 1'b1;
          o_mem_read_c  = 1'b1;
          o_illegal_c   = 1'b0;
        end
      end
      OPC_STORE: begin
        if (w_funct3 == F3_WORD) begin
          o_imm_c       = w_imm_s;
          o_use_imm_c   = 1'b1;
          o_rs2_used_c  = 1'b1;
          o_mem_write_c = 1'b1;
          o_illegal_c   = 1'b0;
        end
      end
      OPC_BRANCH: begin
        if (w_funct3 == F3_BEQ) begin
          o_alu_op_c   = ALU_SUB;
          o_rs2_used_c = 1'b1;
          o_branch_c   = 1'b1;
          o_illegal_c  = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes, builds ALU operands, and owns stall/flush/bubble
// and load-use hazard handling for the EX stage.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter bit          HAZARD_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [31:0]       instr_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [2:0]        ALUCtrl_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [4:0]        rd_o,
  output logic              RegWrite_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              MemtoReg_o,
  output logic              Branch_o,
  output logic              illegal_o,
  output logic              load_use_stall_o
);

  alu_op_e           w_alu_op;
  logic [DATA_W-1:0] w_imm;
  logic              w_use_imm;
  logic              w_rs2_used;
  logic              w_reg_write;
  logic              w_mem_read;
  logic              w_mem_write;
  logic              w_branch;
  logic              w_illegal;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic [4:0]        w_rd;
  logic              w_hazard;

  issue_ctrl_t       w_next_ctrl;
  logic [DATA_W-1:0] w_next_data1;
  logic [DATA_W-1:0] w_next_data2;
  logic [DATA_W-1:0] w_next_store;
  logic              w_next_illegal;

  issue_ctrl_t       r_ctrl;
  logic [DATA_W-1:0] r_data1;
  logic [DATA_W-1:0] r_data2;
  logic [DATA_W-1:0] r_store;
  logic              r_illegal;

  alu_op_decoder #(.DATA_W(DATA_W)) u_dec (
    .i_instr       (instr_i),
    .o_alu_op_c    (w_alu_op),
    .o_imm_c       (w_imm),
    .o_use_imm_c   (w_use_imm),
    .o_rs2_used_c  (w_rs2_used),
    .o_reg_write_c (w_reg_write),
    .o_mem_read_c  (w_mem_read),
    .o_mem_write_c (w_mem_write),
    .o_branch_c    (w_branch),
    .o_illegal_c   (w_illegal),
    .o_rs1_c       (w_rs1),
    .o_rs2_c       (w_rs2),
    .o_rd_c        (w_rd)
  );

  // A load in EX whose rd feeds a source the incoming op really reads.
  assign w_hazard = HAZARD_EN && r_ctrl.valid && r_ctrl.mem_read &&
                    (r_ctrl.rd != 5'd0) && valid_i && !w_illegal &&
                    ((r_ctrl.rd == w_rs1) || (w_rs2_used && (r_ctrl.rd == w_rs2)));
  assign load_use_stall_o = w_hazard;

  // Value loaded when neither reset, flush nor stall holds the register.
  always_comb begin
    w_next_ctrl    = CTRL_BUBBLE;
    w_next_data1   = '0;
    w_next_data2   = '0;
    w_next_store   = '0;
    w_next_illegal = 1'b0;
    if (valid_i && !w_hazard) begin
      if (w_illegal) begin
        w_next_illegal = 1'b1;
      end else begin
        w_next_ctrl.valid      = 1'b1;
        w_next_ctrl.alu_op     = w_alu_op;
        w_next_ctrl.rd         = w_rd;
        w_next_ctrl.reg_write  = w_reg_write && (w_rd != 5'd0);
        w_next_ctrl.mem_read   = w_mem_read;
        w_next_ctrl.mem_write  = w_mem_write;
        w_next_ctrl.mem_to_reg = w_mem_read;
        w_next_ctrl.branch     = w_branch;
        w_next_data1           = rs1_data_i;
        w_next_data2           = w_use_imm ? w_imm : rs2_data_i;
        w_next_store           = w_mem_write ? rs2_data_i : '0;
      end
    end
  end

  // The illegal flag is a strict one-cycle pulse, so a hold clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_ctrl    <= CTRL_BUBBLE;
      r_data1   <= '0;
      r_data2   <= '0;
      r_store   <= '0;
      r_illegal <= 1'b0;
    end else if (stall_i) begin
      r_illegal <= 1'b0;
    end else begin
      r_ctrl    <= w_next_ctrl;
      r_data1   <= w_next_data1;
      r_data2   <= w_next_data2;
      r_store   <= w_next_store;
      r_illegal <= w_next_illegal;
    end
  end

  assign valid_o      = r_ctrl.valid;
  assign data1_o      = r_data1;
  assign data2_o      = r_data2;
  assign ALUCtrl_o    = r_ctrl.alu_op;
  assign store_data_o = r_store;
  assign rd_o         = r_ctrl.rd;
  assign RegWrite_o   = r_ctrl.reg_write;
  assign MemRead_o    = r_ctrl.mem_read;
  assign MemWrite_o   = r_ctrl.mem_write;
  assign MemtoReg_o   = r_ctrl.mem_to_reg;
  assign Branch_o     = r_ctrl.branch;
  assign illegal_o    = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vectors, a behavioural model
// of the EX slot checked every cycle, and hand-computed literal expectations.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] instr_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        stall_i;
  logic        flush_i;
  logic        valid_o;
  logic [31:0] data1_o;
  logic [31:0] data2_o;
  logic [2:0]  ALUCtrl_o;
  logic [31:0] store_data_o;
  logic [4:0]  rd_o;
  logic        RegWrite_o;
  logic        MemRead_o;
  logic        MemWrite_o;
  logic        MemtoReg_o;
  logic        Branch_o;
  logic        illegal_o;
  logic        load_use_stall_o;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [2:0]  op;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        br;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    bit          v;
    bit          st;
    bit          fl;
    bit          rs;
  } vec_t;

  localparam logic [31:0] I_ADD3  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_SW    = 32'hFE20AE23; // sw x2,-4(x1)
  localparam logic [31:0] I_LW5   = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] I_ADD6  = 32'h00028333; // add x6,x5,x0
  localparam logic [31:0] I_SRAI  = 32'h4030D213; // srai x4,x1,3
  localparam logic [31:0] I_ADDI0 = 32'h00100013; // addi x0,x0,1

  alu_issue_stage #(.DATA_W(32), .HAZARD_EN(1'b1)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .valid_i          (valid_i),
    .instr_i          (instr_i),
    .rs1_data_i       (rs1_data_i),
    .rs2_data_i       (rs2_data_i),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .valid_o          (valid_o),
    .data1_o          (data1_o),
    .data2_o          (data2_o),
    .ALUCtrl_o        (ALUCtrl_o),
    .store_data_o     (store_data_o),
    .rd_o             (rd_o),
    .RegWrite_o       (RegWrite_o),
    .MemRead_o        (MemRead_o),
    .MemWrite_o       (MemWrite_o),
    .MemtoReg_o       (MemtoReg_o),
    .Branch_o         (Branch_o),
    .illegal_o        (illegal_o),
    .load_use_stall_o (load_use_stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Spec-level meaning of one instruction word in the EX slot.
  function automatic void model_decode(input logic [31:0] ins, input logic [31:0] a,
                                       input logic [31:0] b, output exp_t e,
                                       output bit legal, output bit reads_rs2);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    opc   = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    e = '0;
    legal = 1'b0;
    reads_rs2 = 1'b0;
    e.valid = 1'b1;
    e.d1 = a;
    e.rd = ins[11:7];
    if (opc == 7'h33) begin
      reads_rs2 = 1'b1;
      e.d2 = b;
      e.rw = 1'b1;
      legal = 1'b1;
      if      (f3 == 3'd0 && f7 == 7'h00) e.op = 3'd0;
      else if (f3 == 3'd0 && f7 == 7'h20) e.op = 3'd1;
      else if (f3 == 3'd7 && f7 == 7'h00) e.op = 3'd2;
      else if (f3 == 3'd4 && f7 == 7'h00) e.op = 3'd3;
      else if (f3 == 3'd0 && f7 == 7'h01) e.op = 3'd4;
      else if (f3 == 3'd1 && f7 == 7'h00) e.op = 3'd5;
      else legal = 1'b0;
    end else if (opc == 7'h13 && f3 == 3'd0) begin
      e.d2 = imm_i; e.rw = 1'b1; legal = 1'b1;
    end else if (opc == 7'h13 && f3 == 3'd5 && f7 == 7'h20) begin
      e.op = 3'd6; e.d2 = {27'd0, ins[24:20]}; e.rw = 1'b1; legal = 1'b1;
    end else if (opc == 7'h03 && f3 == 3'd2) begin
      e.d2 = imm_i; e.rw = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; legal = 1'b1;
    end else if (opc == 7'h23 && f3 == 3'd2) begin
      e.d2 = imm_s; e.sd = b; e.mw = 1'b1; reads_rs2 = 1'b1; legal = 1'b1;
    end else if (opc == 7'h63 && f3 == 3'd0) begin
      e.op = 3'd1; e.d2 = b; e.br = 1'b1; reads_rs2 = 1'b1; legal = 1'b1;
    end
    if (e.rd == 5'd0) e.rw = 1'b0;
  endfunction

  // rd of stores/branches and store data of non-stores carry no meaning.
  function automatic exp_t norm(input exp_t e);
    exp_t r;
    r = e;
    if (r.valid && (r.mw || r.br)) r.rd = '0;
    if (r.valid && !r.mw) r.sd = '0;
    return r;
  endfunction

  function automatic exp_t dut_vec();
    exp_t e;
    e.valid = valid_o;  e.d1 = data1_o;   e.d2 = data2_o;    e.op = ALUCtrl_o;
    e.sd = store_data_o; e.rd = rd_o;     e.rw = RegWrite_o; e.mr = MemRead_o;
    e.mw = MemWrite_o;  e.m2r = MemtoReg_o; e.br = Branch_o; e.ill = illegal_o;
    return e;
  endfunction

  exp_t m_q;
  bit   started;

  function automatic bit model_haz(input exp_t q);
    exp_t e;
    bit legal;
    bit r2;
    model_decode(instr_i, rs1_data_i, rs2_data_i, e, legal, r2);
    return q.valid && q.mr && (q.rd != 5'd0) && valid_i && legal &&
           ((q.rd == instr_i[19:15]) || (r2 && (q.rd == instr_i[24:20])));
  endfunction

  // Model of the EX slot, advanced on each rising edge.
  always @(posedge clk) begin
    exp_t nx;
    bit   legal;
    bit   r2;
    bit   haz;
    model_decode(instr_i, rs1_data_i, rs2_data_i, nx, legal, r2);
    haz = started && model_haz(m_q);
    if (rst_i || flush_i) m_q = '0;
    else if (stall_i) m_q.ill = 1'b0;
    else if (haz || !valid_i) m_q = '0;
    else if (!legal) begin m_q = '0; m_q.ill = 1'b1; end
    else m_q = nx;
    started = 1'b1;
  end

  // Every-cycle comparison, mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      exp_t d;
      bit   h;
      d = norm(dut_vec());
      h = model_haz(m_q);
      n_total++;
      if (d === norm(m_q)) n_pass++;
      else $display("FAIL cycle_outputs t=%0t: got %h, expected %h", $time, d, norm(m_q));
      n_total++;
      if (load_use_stall_o === h) n_pass++;
      else $display("FAIL cycle_load_use t=%0t: got %b, expected %b", $time, load_use_stall_o, h);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input bit v, input bit st, input bit fl, input bit rs);
    instr_i = ins; rs1_data_i = a; rs2_data_i = b;
    valid_i = v; stall_i = st; flush_i = fl; rst_i = rs;
  endtask

  vec_t tbl[$];

  initial begin
    drive(I_ADD3, 32'd5, 32'hFFFF_FFF9, 1, 0, 0, 1);
    // Reset held with a valid instruction present.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_all_zero", 128'(dut_vec()), 128'd0);
    end
    // add x3,x1,x2
    drive(I_ADD3, 32'd5, 32'hFFFF_FFF9, 1, 0, 0, 0);
    tick();
    chk("add_data1", 128'(data1_o), 128'd5);
    chk("add_data2", 128'(data2_o), 128'hFFFF_FFF9);
    chk("add_op", 128'(ALUCtrl_o), 128'd0);
    chk("add_rd", 128'(rd_o), 128'd3);
    chk("add_regwrite", 128'(RegWrite_o), 128'd1);
    // sw x2,-4(x1)
    drive(I_SW, 32'h100, 32'h55, 1, 0, 0, 0);
    tick();
    chk("sw_data2", 128'(data2_o), 128'hFFFF_FFFC);
    chk("sw_op", 128'(ALUCtrl_o), 128'd0);
    chk("sw_memwrite", 128'(MemWrite_o), 128'd1);
    chk("sw_regwrite", 128'(RegWrite_o), 128'd0);
    chk("sw_store_data", 128'(store_data_o), 128'h55);
    // lw x5 then dependent add x6,x5,x0
    drive(I_LW5, 32'h200, 32'h0, 1, 0, 0, 0);
    tick();
    chk("lw_memread", 128'(MemRead_o), 128'd1);
    drive(I_ADD6, 32'h11, 32'h0, 1, 0, 0, 0);
    #1;
    chk("lu_stall_on", 128'(load_use_stall_o), 128'd1);
    tick();
    chk("lu_bubble_valid", 128'(valid_o), 128'd0);
    chk("lu_stall_off", 128'(load_use_stall_o), 128'd0);
    tick();
    chk("lu_add_valid", 128'(valid_o), 128'd1);
    chk("lu_add_op", 128'(ALUCtrl_o), 128'd0);
    chk("lu_add_rd", 128'(rd_o), 128'd6);
    // srai x4,x1,3 then stall, then flush during the stall
    drive(I_SRAI, 32'h80, 32'h0, 1, 0, 0, 0);
    tick();
    drive(I_ADD3, 32'h1, 32'h2, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_op", 128'(ALUCtrl_o), 128'd6);
      chk("stall_data2", 128'(data2_o), 128'd3);
    end
    drive(I_ADD3, 32'h1, 32'h2, 1, 1, 1, 0);
    tick();
    chk("flush_valid", 128'(valid_o), 128'd0);
    chk("flush_data2", 128'(data2_o), 128'd0);
    // Illegal word, then addi x0
    drive(32'hFFFF_FFFF, 32'h1, 32'h2, 1, 0, 0, 0);
    tick();
    chk("illegal_pulse", 128'(illegal_o), 128'd1);
    chk("illegal_valid", 128'(valid_o), 128'd0);
    drive(I_ADDI0, 32'h0, 32'h0, 1, 0, 0, 0);
    tick();
    chk("illegal_cleared", 128'(illegal_o), 128'd0);
    chk("addi_x0_regwrite", 128'(RegWrite_o), 128'd0);
    chk("addi_x0_valid", 128'(valid_o), 128'd1);

    // Model-checked sequence covering hazard corners and the remaining ops.
    tbl.push_back('{I_LW5,        1, 0, 0, 0});
    tbl.push_back('{32'h0050A023, 1, 0, 0, 0}); // sw x5,0(x1): rs2 hazard
    tbl.push_back('{32'h0050A023, 1, 0, 0, 0});
    tbl.push_back('{I_LW5,        1, 0, 0, 0});
    tbl.push_back('{32'h00508313, 1, 0, 0, 0}); // addi x6,x1,5: imm bits look like x5
    tbl.push_back('{I_LW5,        1, 0, 0, 0});
    tbl.push_back('{I_ADD6,       1, 1, 0, 0}); // hazard under stall
    tbl.push_back('{I_ADD6,       1, 0, 0, 0});
    tbl.push_back('{I_ADD6,       1, 0, 0, 0});
    tbl.push_back('{I_LW5,        1, 0, 0, 0});
    tbl.push_back('{I_ADD6,       1, 0, 1, 0}); // hazard under flush
    tbl.push_back('{I_ADD6,       1, 0, 0, 0});
    tbl.push_back('{I_LW5,        1, 0, 0, 0});
    tbl.push_back('{I_ADD6,       1, 0, 0, 1}); // reset mid-hazard
    tbl.push_back('{I_ADD6,       1, 0, 0, 0});
    tbl.push_back('{32'h0000A003, 1, 0, 0, 0}); // lw x0
    tbl.push_back('{32'h00000333, 1, 0, 0, 0}); // add x6,x0,x0
    tbl.push_back('{32'h402083B3, 1, 0, 0, 0}); // sub
    tbl.push_back('{32'h0020F433, 1, 0, 0, 0}); // and
    tbl.push_back('{32'h0020C4B3, 1, 0, 0, 0}); // xor
    tbl.push_back('{32'h02208533, 1, 0, 0, 0}); // mul
    tbl.push_back('{32'h002095B3, 1, 0, 0, 0}); // sll
    tbl.push_back('{32'h00208463, 1, 0, 0, 0}); // beq
    tbl.push_back('{32'hFFF08613, 1, 0, 0, 0}); // addi x12,x1,-1
    tbl.push_back('{32'h4020F433, 1, 1, 0, 0}); // illegal held
    tbl.push_back('{32'h4020F433, 1, 0, 1, 0}); // illegal flushed
    tbl.push_back('{32'h4020F433, 1, 0, 0, 0}); // illegal pulses
    tbl.push_back('{I_ADD3,       0, 0, 0, 0}); // not valid
    tbl.push_back('{I_ADD3,       1, 0, 0, 0});
    foreach (tbl[i]) begin
      drive(tbl[i].ins, 32'(i * 37 + 1), 32'hF000_0000 ^ 32'(i),
            tbl[i].v, tbl[i].st, tbl[i].fl, tbl[i].rs);
      tick();
    end
    drive(I_ADD3, 32'h0, 32'h0, 0, 0, 0, 0);
    tick();
    tick();
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
